// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding and default limits for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  localparam int DEF_TIMEOUT    = 255;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Per-transaction watchdog: cleared on grant, counts BUSY cycles without a ready strobe.
module mem_port_arbiter_timeout
  import mem_port_arbiter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Fires in the cycle whose increment would reach TIMEOUT, so the abort lands after TIMEOUT cycles.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and data requesters, with data
// priority, a fetch anti-starvation guard and a timeout abort per transaction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_stall_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_ack_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_stall_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ready_i,
  output logic                bus_err_o
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_e          state, state_nx;
  logic                flushed, flushed_nx;
  logic [STARVE_W-1:0] starve, starve_nx;
  logic                req_nx, we_nx, if_ack_nx, dm_ack_nx, err_nx;
  logic [BE_W-1:0]     be_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   wdata_nx, if_rdata_nx, dm_rdata_nx;
  logic                busy, done, abort, grant_d, grant_i, fetch_dead;

  assign busy    = (state != ARB_IDLE);
  assign done    = busy && mem_ready_i;
  assign grant_d = (state == ARB_IDLE) && dm_req_i && ((starve < STARVE_LIM) || !if_req_i);
  assign grant_i = (state == ARB_IDLE) && !grant_d && if_req_i && !if_flush_i;
  assign fetch_dead = flushed || if_flush_i;

  assign if_stall_o = if_req_i && !if_ack_o && !if_flush_i;
  assign dm_stall_o = dm_req_i && !dm_ack_o;

  mem_port_arbiter_timeout #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .clear   (grant_d || grant_i),
    .enable  (busy && !mem_ready_i),
    .expired (abort)
  );

  always_comb begin
    state_nx    = state;
    flushed_nx  = flushed;
    starve_nx   = starve;
    req_nx      = mem_req_o;
    we_nx       = mem_we_o;
    be_nx       = mem_be_o;
    addr_nx     = mem_addr_o;
    wdata_nx    = mem_wdata_o;
    if_ack_nx   = 1'b0;
    dm_ack_nx   = 1'b0;
    err_nx      = 1'b0;
    if_rdata_nx = if_rdata_o;
    dm_rdata_nx = dm_rdata_o;

    if (!if_req_i || grant_i) begin
      starve_nx = '0;
    end else if (grant_d && (starve != STARVE_LIM)) begin
      starve_nx = starve + 1'b1;
    end

    case (state)
      ARB_IDLE: begin
        if (grant_d) begin
          state_nx   = ARB_BUSY_D;
          req_nx     = 1'b1;
          we_nx      = dm_we_i;
          be_nx      = dm_be_i;
          addr_nx    = dm_addr_i;
          wdata_nx   = dm_wdata_i;
          flushed_nx = 1'b0;
        end else if (grant_i) begin
          state_nx   = ARB_BUSY_I;
          req_nx     = 1'b1;
          we_nx      = 1'b0;
          be_nx      = '1;
          addr_nx    = if_addr_i;
          wdata_nx   = '0;
          flushed_nx = 1'b0;
        end
      end
      ARB_BUSY_I: begin
        // A squashed fetch still has to finish on the bus; only its ack is swallowed.
        flushed_nx = fetch_dead;
        if (done || abort) begin
          state_nx = ARB_IDLE;
          req_nx   = 1'b0;
          if (!fetch_dead) begin
            if_ack_nx   = 1'b1;
            err_nx      = abort;
            if_rdata_nx = done ? mem_rdata_i : '0;
          end
        end
      end
      ARB_BUSY_D: begin
        if (done || abort) begin
          state_nx    = ARB_IDLE;
          req_nx      = 1'b0;
          dm_ack_nx   = 1'b1;
          err_nx      = abort;
          dm_rdata_nx = done ? mem_rdata_i : '0;
        end
      end
      default: begin
        state_nx = ARB_IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ARB_IDLE;
      flushed     <= 1'b0;
      starve      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      bus_err_o   <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      state       <= state_nx;
      flushed     <= flushed_nx;
      starve      <= starve_nx;
      mem_req_o   <= req_nx;
      mem_we_o    <= we_nx;
      mem_be_o    <= be_nx;
      mem_addr_o  <= addr_nx;
      mem_wdata_o <= wdata_nx;
      if_ack_o    <= if_ack_nx;
      dm_ack_o    <= dm_ack_nx;
      bus_err_o   <= err_nx;
      if_rdata_o  <= if_rdata_nx;
      dm_rdata_o  <= dm_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: a memory responder model checks every bus
// transaction and every ack against queued expectations.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  typedef struct packed {
    logic        is_data;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  logic        clk_i, rst_i;
  logic        if_req_i, if_flush_i, if_ack_o, if_stall_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_ack_o, dm_stall_o;
  logic [3:0]  dm_be_i, mem_be_o;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ready_i, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int   total, bad;
  txn_t mem_q[$];
  txn_t cur, due_txn;
  logic cur_flushed, due, due_err, due_flushed, idle_ready;
  int   busy_k, ready_delay, if_more, dm_more;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CNT_W(8), .STARVE_MAX(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .bus_err_o(bus_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic is_data, input logic [31:0] addr, input logic we,
                              input logic [3:0] be, input logic [31:0] wdata);
    txn_t t;
    t = '{is_data: is_data, addr: addr, we: we, be: be, wdata: wdata};
    mem_q.push_back(t);
  endtask

  task automatic applyStimulus(input logic is_data, input logic [31:0] addr, input logic we,
                               input logic [3:0] be, input logic [31:0] wdata, input int more);
    if (is_data) begin
      dm_req_i = 1'b1; dm_addr_i = addr; dm_we_i = we; dm_be_i = be; dm_wdata_i = wdata;
      dm_more = more;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr; if_more = more;
    end
  endtask

  // One clock: check acks due from last cycle, check the bus, then drive the memory model.
  task automatic tick();
    logic exp_if, exp_dm, exp_err;
    logic [31:0] exp_rdata;
    @(posedge clk_i);
    #1;
    exp_if    = due && !due_txn.is_data && !due_flushed;
    exp_dm    = due && due_txn.is_data;
    exp_err   = (exp_if || exp_dm) && due_err;
    exp_rdata = due_err ? 32'h0 : mem_fn(due_txn.addr);
    checkOutput("acks", {61'b0, if_ack_o, dm_ack_o, bus_err_o}, {61'b0, exp_if, exp_dm, exp_err});
    if (due) checkOutput("mem_req_drop", {63'b0, mem_req_o}, 64'h0);
    if (exp_if) checkOutput("if_rdata", {32'b0, if_rdata_o}, {32'b0, exp_rdata});
    if (exp_dm && !due_txn.we) checkOutput("dm_rdata", {32'b0, dm_rdata_o}, {32'b0, exp_rdata});
    if (if_ack_o) begin
      if (if_more > 0) begin if_more--; if_addr_i += 32'h4; end
      else if_req_i = 1'b0;
    end
    if (dm_ack_o) begin
      if (dm_more > 0) begin dm_more--; dm_addr_i += 32'h4; end
      else dm_req_i = 1'b0;
    end
    due = 1'b0;
    if (mem_req_o) begin
      if (busy_k == 0) begin
        if (mem_q.size() == 0) begin
          checkOutput("unexpected_mem_req", {63'b0, mem_req_o}, 64'h0);
        end else begin
          cur = mem_q.pop_front();
          cur_flushed = 1'b0;
        end
      end
      checkOutput("mem_addr", {32'b0, mem_addr_o}, {32'b0, cur.addr});
      checkOutput("mem_ctrl", {27'b0, mem_we_o, mem_be_o, mem_wdata_o}, {27'b0, cur.we, cur.be, cur.wdata});
      busy_k++;
      mem_ready_i = (ready_delay >= 0) && (busy_k == ready_delay + 1);
      mem_rdata_i = mem_ready_i ? mem_fn(mem_addr_o) : $urandom;
      due         = mem_ready_i || (busy_k == TO);
      due_err     = !mem_ready_i;
      due_txn     = cur;
      due_flushed = cur_flushed;
    end else begin
      busy_k      = 0;
      mem_ready_i = idle_ready;
      mem_rdata_i = $urandom;
    end
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(mem_q.size() == 0 && !mem_req_o && !due) && n < budget);
    if (n >= budget) checkOutput({tag, "_drain_budget"}, 64'(mem_q.size()) + 64'(due), 64'h0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_i = 1'b0;
    if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
    dm_req_i = 0; dm_we_i = 0; dm_be_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
    mem_ready_i = 0; mem_rdata_i = 0;
    cur = '0; due_txn = '0; cur_flushed = 0; due = 0; due_err = 0; due_flushed = 0;
    idle_ready = 0; busy_k = 0; ready_delay = -1; if_more = 0; dm_more = 0;

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_ctrl", {57'b0, mem_req_o, if_ack_o, dm_ack_o, bus_err_o, mem_we_o, mem_be_o}, 64'h0);
    checkOutput("reset_rdata", {if_rdata_o, dm_rdata_o}, 64'h0);
    checkOutput("reset_bus", {mem_addr_o, mem_wdata_o}, 64'h0);
    rst_i = 1'b1;
    tick();

    $display("[TB] fetch only, ready two cycles after request");
    ready_delay = 2;
    pushExpected(0, 32'h100, 0, 4'hF, 32'h0);
    applyStimulus(0, 32'h100, 0, 4'h0, 32'h0, 0);
    #1 checkOutput("t1_if_stall", {63'b0, if_stall_o}, 64'h1);
    tick();
    checkOutput("t1_grant_latency", {63'b0, mem_req_o}, 64'h1);
    waitDrain("t1", 20);

    $display("[TB] simultaneous store and fetch");
    idle_ready = 1; ready_delay = 1;
    pushExpected(1, 32'h2000, 1, 4'h3, 32'hDEADBEEF);
    pushExpected(0, 32'h104, 0, 4'hF, 32'h0);
    applyStimulus(1, 32'h2000, 1, 4'h3, 32'hDEADBEEF, 0);
    applyStimulus(0, 32'h104, 0, 4'h0, 32'h0, 0);
    waitDrain("t2", 30);

    $display("[TB] continuous contention, starvation guard");
    ready_delay = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) pushExpected(0, 32'h400 + ((i == 9) ? 32'h4 : 32'h0), 0, 4'hF, 32'h0);
      else pushExpected(1, 32'h3000 + 32'((i > 4) ? i - 1 : i) * 4, 0, 4'hF, 32'h0);
    end
    applyStimulus(1, 32'h3000, 0, 4'hF, 32'h0, 7);
    applyStimulus(0, 32'h400, 0, 4'h0, 32'h0, 1);
    waitDrain("t3", 60);

    $display("[TB] timeout abort then normal load");
    idle_ready = 0; ready_delay = -1;
    pushExpected(1, 32'h5000, 0, 4'hF, 32'h0);
    applyStimulus(1, 32'h5000, 0, 4'hF, 32'h0, 0);
    #1 checkOutput("t4_dm_stall", {63'b0, dm_stall_o}, 64'h1);
    waitDrain("t4a", 30);
    ready_delay = 1;
    pushExpected(1, 32'h5004, 0, 4'hF, 32'h0);
    applyStimulus(1, 32'h5004, 0, 4'hF, 32'h0, 0);
    waitDrain("t4b", 20);

    $display("[TB] fetch flush while busy and while idle");
    ready_delay = 4;
    pushExpected(0, 32'h200, 0, 4'hF, 32'h0);
    applyStimulus(0, 32'h200, 0, 4'h0, 32'h0, 0);
    tick();
    tick();
    if_flush_i = 1'b1; cur_flushed = 1'b1;
    #1 checkOutput("t5_if_stall_flush", {63'b0, if_stall_o}, 64'h0);
    tick();
    checkOutput("t5_hold_req", {63'b0, mem_req_o}, 64'h1);
    if_flush_i = 1'b0; if_req_i = 1'b0;
    waitDrain("t5a", 20);
    applyStimulus(0, 32'h300, 0, 4'h0, 32'h0, 0);
    if_flush_i = 1'b1;
    tick();
    checkOutput("t5_idle_flush_blocks", {63'b0, mem_req_o}, 64'h0);
    if_flush_i = 1'b0;
    pushExpected(0, 32'h300, 0, 4'hF, 32'h0);
    waitDrain("t5b", 20);

    $display("[TB] reset mid data transaction");
    ready_delay = -1;
    pushExpected(1, 32'h6000, 1, 4'hC, 32'h12345678);
    applyStimulus(1, 32'h6000, 1, 4'hC, 32'h12345678, 0);
    applyStimulus(0, 32'h500, 0, 4'h0, 32'h0, 0);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    checkOutput("t6_reset_ctrl", {57'b0, mem_req_o, if_ack_o, dm_ack_o, bus_err_o, mem_we_o, mem_be_o}, 64'h0);
    checkOutput("t6_reset_bus", {mem_addr_o, mem_wdata_o}, 64'h0);
    dm_req_i = 0; if_req_i = 0; dm_more = 0; if_more = 0;
    busy_k = 0; due = 0; mem_ready_i = 0; mem_q.delete();
    @(posedge clk_i);
    #1 checkOutput("t6_in_reset", {63'b0, mem_req_o}, 64'h0);
    rst_i = 1'b1;
    tick();
    checkOutput("t6_idle_after", {63'b0, mem_req_o}, 64'h0);
    ready_delay = 0;
    for (int i = 0; i < 4; i++) pushExpected(1, 32'h7000 + 32'(i) * 4, 0, 4'hF, 32'h0);
    pushExpected(0, 32'h600, 0, 4'hF, 32'h0);
    applyStimulus(1, 32'h7000, 0, 4'hF, 32'h0, 3);
    applyStimulus(0, 32'h600, 0, 4'h0, 32'h0, 0);
    waitDrain("t6a", 30);
    ready_delay = -1;
    pushExpected(1, 32'h7100, 0, 4'hF, 32'h0);
    applyStimulus(1, 32'h7100, 0, 4'hF, 32'h0, 0);
    waitDrain("t6b", 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
